enc32t5_arb: RTL and testbench

- Registered priority encoder with request latching and a valid/ack handshake. It is the inverse of the 5-to-32 enabled one-hot decoder.
- Collects up to 32 single-cycle request pulses into a pending register. It presents the lowest-numbered unmasked pending line as a 5-bit index and clears that line when the consumer acknowledges it.
- Sits between peripheral/exception sources and CPU control. The control unit consumes `idx`, e.g. to drive the decoder back to a one-hot select.

---
 rtl/enc32t5_arb.sv | 91 +++++++++
 tb/tb_enc32t5_arb.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/enc32t5_arb.sv
// Registered priority encoder: latches request pulses into a pending vector and
// hands out the lowest unmasked pending line through a valid/ack handshake.
module enc32t5_arb #(
    parameter int IDX_W = 5,
    localparam int N = 2 ** IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    input  logic             en,
    input  logic             ack,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     pend,
    output logic [IDX_W:0]   pend_cnt,
    output logic [0:0]       dbg_state
);

    // Handshake: idx is offered while valid=1 and stays frozen until the cycle
    // in which ack=1 is sampled; ack with valid=0 has no effect at all.
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]       state;
    logic [N-1:0]     sel_oh;
    logic             take;
    logic [N-1:0]     clr;
    logic [N-1:0]     cand;
    logic [N-1:0]     pend_next;
    logic [IDX_W-1:0] low_idx;
    logic             grant_ok;

    function automatic logic [IDX_W-1:0] lowest(input logic [N-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    assign sel_oh    = {{(N-1){1'b0}}, 1'b1} << idx;
    assign take      = (state == HOLD) && ack;
    assign clr       = take ? sel_oh : '0;
    // A request arriving on the line being cleared wins: the bit stays pending.
    assign pend_next = (pend & ~clr) | req;
    // The line being acknowledged is excluded so a back-to-back grant moves on.
    assign cand      = pend & ~mask & (take ? ~sel_oh : {N{1'b1}});
    assign low_idx   = lowest(cand);
    assign grant_ok  = en && (cand != '0);

    assign valid     = (state == HOLD);
    assign dbg_state = state;

    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < N; i++) begin
            pend_cnt = pend_cnt + (IDX_W + 1)'(pend[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            pend  <= '0;
        end else begin
            pend <= pend_next;
            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        idx   <= low_idx;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (ack) begin
                        if (grant_ok) begin
                            idx <= low_idx;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_enc32t5_arb.sv
// Directed bench for enc32t5_arb: a vector table for the single-cycle stepping
// plus hand-written sequences for collision, no-retraction, reset and full load.
module tb_enc32t5_arb;

    logic        clk;
    logic        rst;
    logic [31:0] req;
    logic [31:0] mask;
    logic        en;
    logic        ack;
    logic        valid;
    logic [4:0]  idx;
    logic [31:0] pend;
    logic [5:0]  pend_cnt;
    logic [0:0]  dbg_state;

    int total;
    int bad;

    typedef struct {
        logic        rst;
        logic [31:0] req;
        logic [31:0] mask;
        logic        en;
        logic        ack;
        logic        exp_valid;
        logic [4:0]  exp_idx;
        logic [31:0] exp_pend;
        logic [5:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];

    enc32t5_arb dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .mask(mask),
        .en(en),
        .ack(ack),
        .valid(valid),
        .idx(idx),
        .pend(pend),
        .pend_cnt(pend_cnt),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [31:0] q, input logic [31:0] m,
                         input logic e, input logic a);
        rst  = r;
        req  = q;
        mask = m;
        en   = e;
        ack  = a;
    endtask

    task automatic add(input logic r, input logic [31:0] q, input logic [31:0] m,
                       input logic e, input logic a, input logic v, input logic [4:0] i,
                       input logic [31:0] p, input logic [5:0] c);
        vec_t t;
        t.rst = r; t.req = q; t.mask = m; t.en = e; t.ack = a;
        t.exp_valid = v; t.exp_idx = i; t.exp_pend = p; t.exp_cnt = c;
        vecs.push_back(t);
    endtask

    // scoreboard
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [4:0] i,
                             input logic [31:0] p, input logic [5:0] c);
        check({tag, ".valid"}, 32'(valid), 32'(v));
        check({tag, ".idx"}, 32'(idx), 32'(i));
        check({tag, ".pend"}, pend, p);
        check({tag, ".pend_cnt"}, 32'(pend_cnt), 32'(c));
        check({tag, ".state"}, 32'(dbg_state), 32'(v));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        drive(1'b1, 32'h0, 32'h0, 1'b1, 1'b0);

        // reset holds everything at zero even with all requests asserted
        add(1, 32'hFFFF_FFFF, 0, 1, 0, 0, 0, 32'h0, 0);
        add(1, 32'hFFFF_FFFF, 0, 1, 0, 0, 0, 32'h0, 0);
        add(0, 32'h0, 0, 1, 0, 0, 0, 32'h0, 0);
        add(0, 32'h0, 0, 1, 0, 0, 0, 32'h0, 0);
        // single request: latched, granted one cycle later, held until ack
        add(0, 32'h0000_0100, 0, 1, 0, 0, 0, 32'h0000_0100, 1);
        add(0, 32'h0, 0, 1, 0, 1, 8, 32'h0000_0100, 1);
        for (int k = 0; k < 5; k++) add(0, 32'h0, 0, 1, 0, 1, 8, 32'h0000_0100, 1);
        add(0, 32'h0, 0, 1, 1, 0, 8, 32'h0, 0);
        // priority + back-to-back; the first ack arrives while valid=0 and is ignored
        add(0, 32'h8000_0024, 0, 1, 1, 0, 8, 32'h8000_0024, 3);
        add(0, 32'h0, 0, 1, 1, 1, 2, 32'h8000_0024, 3);
        add(0, 32'h0, 0, 1, 1, 1, 5, 32'h8000_0020, 2);
        add(0, 32'h0, 0, 1, 1, 1, 31, 32'h8000_0000, 1);
        add(0, 32'h0, 0, 1, 1, 0, 31, 32'h0, 0);
        // mask and enable
        add(0, 32'h3, 32'h1, 0, 0, 0, 31, 32'h3, 2);
        add(0, 32'h0, 32'h1, 0, 0, 0, 31, 32'h3, 2);
        add(0, 32'h0, 32'h1, 0, 0, 0, 31, 32'h3, 2);
        add(0, 32'h0, 32'h1, 1, 0, 1, 1, 32'h3, 2);
        add(0, 32'h0, 32'h0, 1, 1, 1, 0, 32'h1, 1);
        add(0, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0, 0);

        for (int n = 0; n < vecs.size(); n++) begin
            drive(vecs[n].rst, vecs[n].req, vecs[n].mask, vecs[n].en, vecs[n].ack);
            tick();
            check_out($sformatf("vec%0d", n), vecs[n].exp_valid, vecs[n].exp_idx,
                      vecs[n].exp_pend, vecs[n].exp_cnt);
        end

        // set/clear collision on idx=4: the bit survives and is granted again
        drive(0, 32'h10, 0, 1, 0); tick();
        check_out("coll.latch", 0, 0, 32'h10, 1);
        drive(0, 32'h0, 0, 1, 0); tick();
        check_out("coll.grant", 1, 4, 32'h10, 1);
        drive(0, 32'h10, 0, 1, 1); tick();
        check_out("coll.ack", 0, 4, 32'h10, 1);
        drive(0, 32'h0, 0, 1, 0); tick();
        check_out("coll.regrant", 1, 4, 32'h10, 1);
        drive(0, 32'h0, 0, 1, 1); tick();
        check_out("coll.done", 0, 4, 32'h0, 0);

        // no retraction: idx=7 survives a higher request, en=0 and its own mask
        drive(0, 32'h80, 0, 1, 0); tick();
        drive(0, 32'h0, 0, 1, 0); tick();
        check_out("hold.grant", 1, 7, 32'h80, 1);
        drive(0, 32'h1, 32'h80, 0, 0); tick();
        check_out("hold.disturb", 1, 7, 32'h81, 2);
        for (int k = 0; k < 3; k++) begin
            drive(0, 32'h0, 32'h80, 0, 0); tick();
            check_out($sformatf("hold.stay%0d", k), 1, 7, 32'h81, 2);
        end
        drive(0, 32'h0, 32'h80, 0, 1); tick();
        check_out("hold.ack", 0, 7, 32'h1, 1);
        drive(0, 32'h0, 32'h0, 0, 0); tick();
        check_out("hold.idle", 0, 7, 32'h1, 1);
        drive(0, 32'h0, 32'h0, 1, 0); tick();
        check_out("hold.release", 1, 0, 32'h1, 1);

        // reset mid-handshake drops valid without an ack
        drive(1, 32'h4, 32'h0, 1, 0); tick();
        check_out("rst.mid", 0, 0, 32'h0, 0);

        // all 32 lines pending: ascending grants, one per acked cycle
        drive(0, 32'hFFFF_FFFF, 32'h0, 1, 0); tick();
        check_out("all.latch", 0, 0, 32'hFFFF_FFFF, 32);
        drive(0, 32'h0, 32'h0, 1, 1); tick();
        check_out("all.g0", 1, 0, 32'hFFFF_FFFF, 32);
        for (int k = 1; k < 32; k++) begin
            logic [31:0] exp_p;
            exp_p = 32'hFFFF_FFFF << k;
            tick();
            check_out($sformatf("all.g%0d", k), 1, 5'(k), exp_p, 6'(32 - k));
        end
        tick();
        check_out("all.done", 0, 31, 32'h0, 0);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
